// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Logic, shift and LUI results are combinational from the ID/EX inputs.
// DIV/DIVU run on a 32-step restoring divider that stalls the front end and
// produces HI (remainder) and LO (quotient) with a one-cycle whilo_o pulse.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req_o
);

    localparam logic [2:0] TYPE_NOP   = 3'b000;
    localparam logic [2:0] TYPE_LOGIC = 3'b001;
    localparam logic [2:0] TYPE_SHIFT = 3'b010;
    localparam logic [2:0] TYPE_DIV   = 3'b011;

    localparam logic [7:0] SUB_TYPE_AND  = 8'b0010_0100;
    localparam logic [7:0] SUB_TYPE_OR   = 8'b0010_0101;
    localparam logic [7:0] SUB_TYPE_XOR  = 8'b0010_0110;
    localparam logic [7:0] SUB_TYPE_NOR  = 8'b0010_0111;
    localparam logic [7:0] SUB_TYPE_LUI  = 8'b0101_1100;
    localparam logic [7:0] SUB_TYPE_SLL  = 8'b0111_1100;
    localparam logic [7:0] SUB_TYPE_SRL  = 8'b0000_0010;
    localparam logic [7:0] SUB_TYPE_SRA  = 8'b0000_0011;
    localparam logic [7:0] SUB_TYPE_DIV  = 8'b0001_1010;
    localparam logic [7:0] SUB_TYPE_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dvd_q, dvd_d;      // {remainder[32:0], dividend/quotient[31:0]}
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        div_op;
    logic        div_signed;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [33:0] rem_sh;
    logic [64:0] step_res;
    logic [31:0] alu_res;
    logic [4:0]  sa;

    assign div_op     = (alusel_i == TYPE_DIV) &&
                        ((aluop_i == SUB_TYPE_DIV) || (aluop_i == SUB_TYPE_DIVU));
    assign div_signed = (aluop_i == SUB_TYPE_DIV);
    assign op1_abs    = (div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign op2_abs    = (div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    assign sa         = reg1_i[4:0];

    // One restoring step: shift left, subtract divisor if it fits, set quotient bit
    always_comb begin
        rem_sh = {dvd_q[64:31]};
        if (rem_sh >= {2'b00, dvs_q}) begin
            step_res = {rem_sh[32:0] - {1'b0, dvs_q}, dvd_q[30:0], 1'b1};
        end else begin
            step_res = {rem_sh[32:0], dvd_q[30:0], 1'b0};
        end
    end

    // Combinational logic/shift/LUI result
    always_comb begin
        alu_res = '0;
        case (alusel_i)
            TYPE_LOGIC: begin
                case (aluop_i)
                    SUB_TYPE_AND: alu_res = reg1_i & reg2_i;
                    SUB_TYPE_OR:  alu_res = reg1_i | reg2_i;
                    SUB_TYPE_XOR: alu_res = reg1_i ^ reg2_i;
                    SUB_TYPE_NOR: alu_res = ~(reg1_i | reg2_i);
                    SUB_TYPE_LUI: alu_res = {reg2_i[15:0], 16'h0000};
                    default:      alu_res = '0;
                endcase
            end
            TYPE_SHIFT: begin
                case (aluop_i)
                    SUB_TYPE_SLL: alu_res = reg2_i << sa;
                    SUB_TYPE_SRL: alu_res = reg2_i >> sa;
                    SUB_TYPE_SRA: alu_res = $unsigned($signed(reg2_i) >>> sa);
                    default:      alu_res = '0;
                endcase
            end
            TYPE_NOP: alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

    // Divider next-state: start from IDLE, step in BUSY, pulse in DONE; flush wins
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (div_op && !flush_i) begin
                    cnt_d     = '0;
                    dvd_d     = {33'd0, op1_abs};
                    dvs_d     = op2_abs;
                    neg_quo_d = div_signed && (reg1_i[31] ^ reg2_i[31]);
                    neg_rem_d = div_signed && reg1_i[31];
                    if (reg2_i == 32'd0) begin
                        hi_d    = reg1_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dvd_d = step_res;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    lo_d    = neg_quo_q ? (~step_res[31:0] + 32'd1) : step_res[31:0];
                    hi_d    = neg_rem_q ? (~step_res[63:32] + 32'd1) : step_res[63:32];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Divider registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Output forwarding; everything forced to zero while reset is held
    always_comb begin
        wd_o        = rst ? 5'd0 : wd_i;
        wreg_o      = !rst && !div_op && wreg_i;
        wdata_o     = (rst || div_op) ? 32'd0 : alu_res;
        whilo_o     = !rst && (state_q == DONE) && !flush_i;
        hi_o        = rst ? 32'd0 : hi_q;
        lo_o        = rst ? 32'd0 : lo_q;
        stall_req_o = !rst && ((state_q == BUSY) ||
                               ((state_q == IDLE) && div_op && !flush_i));
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven check of ex_stage ALU ops plus
// hand-written divider sequences (timing, signed, divide-by-zero, flush, reset).
module tb_ex_stage;

    localparam logic [2:0] TYPE_NOP   = 3'b000;
    localparam logic [2:0] TYPE_LOGIC = 3'b001;
    localparam logic [2:0] TYPE_SHIFT = 3'b010;
    localparam logic [2:0] TYPE_DIV   = 3'b011;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_LUI  = 8'b0101_1100;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst, flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stall_req_o;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wr);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wr;
    endtask

    task automatic run_div(input string nm, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input int est);
        int  stalls = 0;
        int  cyc = 0;
        bit  done = 1'b0;
        bit  wbad = 1'b0;
        @(posedge clk); #1;
        set_in(op, TYPE_DIV, a, b, 5'd9, 1'b1);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stall_req_o) stalls++;
            if (wreg_o !== 1'b0 || wdata_o !== 32'd0) wbad = 1'b1;
            if (whilo_o === 1'b1) begin
                done = 1'b1;
                chk({nm, " lo"}, lo_o, elo);
                chk({nm, " hi"}, hi_o, ehi);
                chk({nm, " stall in done"}, stall_req_o, 1'b0);
            end
        end
        chk({nm, " done seen"}, done, 1'b1);
        chk({nm, " stall cycles"}, stalls, est);
        chk({nm, " wreg/wdata zero"}, wbad, 1'b0);
        @(posedge clk); #1;
        set_in(8'h00, TYPE_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk({nm, " single whilo"}, whilo_o, 1'b0);
        chk({nm, " idle stall"}, stall_req_o, 1'b0);
        chk({nm, " lo hold"}, lo_o, elo);
        chk({nm, " hi hold"}, hi_o, ehi);
    endtask

    // Abort if anything hangs
    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;

        vecs[0]  = '{"or",      OP_OR,  TYPE_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 5'd7,  1'b1, 32'h0F0F_F0F0};
        vecs[1]  = '{"nor",     OP_NOR, TYPE_LOGIC, 32'h0,         32'h0,         5'd3,  1'b0, 32'hFFFF_FFFF};
        vecs[2]  = '{"lui",     OP_LUI, TYPE_LOGIC, 32'h0000_DEAD, 32'hABCD_1234, 5'd31, 1'b1, 32'h1234_0000};
        vecs[3]  = '{"and",     OP_AND, TYPE_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd1,  1'b1, 32'h0F00_0F00};
        vecs[4]  = '{"xor",     OP_XOR, TYPE_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2,  1'b1, 32'hF0F0_F0F0};
        vecs[5]  = '{"sll4",    OP_SLL, TYPE_SHIFT, 32'hFFFF_FFE4, 32'h8000_0010, 5'd4,  1'b1, 32'h0000_0100};
        vecs[6]  = '{"srl4",    OP_SRL, TYPE_SHIFT, 32'd4,         32'h8000_0010, 5'd5,  1'b1, 32'h0800_0001};
        vecs[7]  = '{"sra4",    OP_SRA, TYPE_SHIFT, 32'd4,         32'h8000_0010, 5'd6,  1'b1, 32'hF800_0001};
        vecs[8]  = '{"sra0",    OP_SRA, TYPE_SHIFT, 32'd0,         32'h8000_0010, 5'd8,  1'b1, 32'h8000_0010};
        vecs[9]  = '{"srl31",   OP_SRL, TYPE_SHIFT, 32'd31,        32'h8000_0010, 5'd10, 1'b1, 32'h0000_0001};
        vecs[10] = '{"sll31",   OP_SLL, TYPE_SHIFT, 32'd31,        32'h0000_0001, 5'd11, 1'b0, 32'h8000_0000};
        vecs[11] = '{"nop",     8'h00,  TYPE_NOP,   32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1, 32'h0};
        vecs[12] = '{"unknown", 8'hEE,  TYPE_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1'b1, 32'h0};

        // Reset with random inputs, including a divide request
        rst = 1'b1; flush_i = 1'b0;
        set_in(OP_DIVU, TYPE_DIV, $urandom, $urandom, 5'($urandom), 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst wd_o", wd_o, 5'd0);
            chk("rst wreg_o", wreg_o, 1'b0);
            chk("rst wdata_o", wdata_o, 32'd0);
            chk("rst whilo_o", whilo_o, 1'b0);
            chk("rst hi_o", hi_o, 32'd0);
            chk("rst lo_o", lo_o, 32'd0);
            chk("rst stall", stall_req_o, 1'b0);
            set_in(OP_OR, TYPE_LOGIC, $urandom, $urandom, 5'($urandom), 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(8'h00, TYPE_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

        // Table-driven combinational ops
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
            #1;
            chk({vecs[i].name, " wdata same cycle"}, wdata_o, vecs[i].exp);
            @(negedge clk);
            chk({vecs[i].name, " wdata"}, wdata_o, vecs[i].exp);
            chk({vecs[i].name, " wd"}, wd_o, vecs[i].wd);
            chk({vecs[i].name, " wreg"}, wreg_o, vecs[i].wreg);
            chk({vecs[i].name, " stall"}, stall_req_o, 1'b0);
            @(posedge clk); #1;
        end

        // Divides
        run_div("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);
        run_div("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);

        // Flush at BUSY step 10
        @(posedge clk); #1;
        set_in(OP_DIVU, TYPE_DIV, 32'd100, 32'd7, 5'd9, 1'b1);
        repeat (11) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("flush stall while busy", stall_req_o, 1'b1);
        chk("flush no whilo", whilo_o, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        set_in(8'h00, TYPE_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("flush stall dropped", stall_req_o, 1'b0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o === 1'b1) pulses++;
        end
        chk("flush whilo pulses", pulses, 0);
        chk("flush lo kept", lo_o, 32'hFFFF_FFFF);

        // Reset at BUSY step 10
        @(posedge clk); #1;
        set_in(OP_DIV, TYPE_DIV, 32'd100, 32'd7, 5'd9, 1'b1);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst mid stall", stall_req_o, 1'b0);
        chk("rst mid whilo", whilo_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(8'h00, TYPE_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rst mid stall after", stall_req_o, 1'b0);
        chk("rst mid hi cleared", hi_o, 32'd0);
        chk("rst mid lo cleared", lo_o, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o === 1'b1) pulses++;
        end
        chk("rst mid whilo pulses", pulses, 0);

        // Divider still works after the abort
        run_div("divu after rst", OP_DIVU, 32'd1000, 32'd33, 32'd30, 32'd10, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operation, operands and destination from the ID/EX register and produces the write-back triple forwarded to MEM and back to decode for bypassing. Logic, shift and LUI operations complete combinationally in one cycle. DIV/DIVU run on an iterative 32-step divider that stalls the front of the pipeline and writes HI/LO.

## Interface
- No parameters. Widths come from `defines.v`: RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  cancel the in-flight instruction; divider returns to IDLE
- aluop_i  in  8  SUB_TYPE_* code
- alusel_i  in  3  TYPE_LOGIC / TYPE_SHIFT / TYPE_NOP / TYPE_DIV
- reg1_i  in  32  operand 1: rs value, or shift amount in bits [4:0]
- reg2_i  in  32  operand 2: rt value, or zero-extended immediate
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wd_o  out  5  forwarded destination address
- wreg_o  out  1  forwarded write enable
- wdata_o  out  32  result; also drives decode's ex_wdata_i bypass
- whilo_o  out  1  HI/LO write enable, pulses for one cycle
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- stall_req_o  out  1  hold PC, IF/ID and ID/EX

## Operation
- LOGIC: AND, OR, XOR, NOR = ~(reg1|reg2). LUI = {reg2_i[15:0], 16'h0}.
- SHIFT: sa = reg1_i[4:0]. SLL = reg2<<sa. SRL is a logical right shift. SRA fills with reg2_i[31].
- NOP or an unknown code: wdata_o = 0. wd_o and wreg_o pass through.
- DIV/DIVU (alusel TYPE_DIV, aluop SUB_TYPE_DIV or SUB_TYPE_DIVU):
  - wreg_o = 0 and wdata_o = 0 for the whole operation.
  - The divider runs unsigned restoring division on magnitudes. It uses a 65-bit {remainder, dividend} shift register and a 6-bit step counter.
  - Signed DIV: |reg1| and |reg2| are used. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - Divide by zero: skip BUSY and go straight to DONE. Result: hi_o = reg1_i, lo_o = 32'hFFFF_FFFF.
- Divider FSM:
  - IDLE: on a DIV op with flush_i = 0, latch the operands, counter = 0, go to BUSY (or DONE if the divisor is 0).
  - BUSY: one shift/subtract step per cycle. Go to DONE when counter = 31.
  - DONE: drop stall_req_o, assert whilo_o, drive hi_o/lo_o, go to IDLE.
- stall_req_o = 1 while in BUSY, and also in the IDLE cycle that starts a divide.
- Upstream holds the inputs stable while stalled. The instruction is still present in the DONE cycle, but must not restart the divider.
- flush_i in any state: go to IDLE next cycle with no whilo_o pulse. stall_req_o follows the state (combinational).
- rst (sync): state IDLE, counter 0, internal divider registers 0.
- While rst = 1: all outputs are 0, including wd_o and wreg_o.

## Timing
- Non-divide ops: zero latency. Outputs are combinational from the inputs and change in the same cycle.
- Divide issued in cycle N:
  - stall_req_o is high in cycles N to N+32, i.e. 33 cycles.
  - DONE is in cycle N+33: whilo_o = 1 and hi_o/lo_o are valid.
  - The next instruction is seen in cycle N+34.
- Divide by zero: stall in cycle N only, DONE in cycle N+1.
- Back-to-back divides: the second starts from IDLE in cycle N+34.
- hi_o and lo_o hold their last value after DONE. Only whilo_o qualifies them.
- rst or flush_i asserted in BUSY: IDLE and stall_req_o = 0 on the next edge.

## Test plan
- Reset: rst = 1 for 2 cycles with random inputs -> every output 0 and stall_req_o = 0.
- Logic/LUI:
  - OR 0x0000_F0F0 | 0x0F0F_0000 -> wdata_o 0x0F0F_F0F0 in the same cycle.
  - NOR 0, 0 -> 0xFFFF_FFFF.
  - LUI reg2 = 0x1234 -> 0x1234_0000.
  - wd_i = 7 and wreg_i = 1 appear on wd_o/wreg_o.
- Shifts with reg2 = 0x8000_0010:
  - SLL sa = 4 -> 0x0000_0100.
  - SRL sa = 4 -> 0x0800_0001.
  - SRA sa = 4 -> 0xF800_0001.
  - SRA sa = 0 -> 0x8000_0010.
- DIVU 100 / 7:
  - stall_req_o high for exactly 33 cycles.
  - DONE: lo_o = 14, hi_o = 2, whilo_o pulses once, wreg_o = 0 throughout.
- Signed DIV:
  - -7 / 2 -> lo_o 0xFFFF_FFFD, hi_o 0xFFFF_FFFF.
  - 7 / -2 -> lo_o 0xFFFF_FFFD, hi_o 1.
- Corner cases:
  - DIVU 5 / 0: stall for 1 cycle, then lo_o 0xFFFF_FFFF and hi_o 5.
  - flush_i at BUSY step 10: no whilo_o pulse, stall_req_o drops next cycle.
  - rst mid-BUSY: the same outcome as the flush case.
